input_conditioner: RTL
======================

Name: input_conditioner

Overview:
- Parametrised successor to the board-level button conditioning chain. One block performs synchronise, debounce, press/release edge detection, long-press detection and auto-repeat.
- Handles WIDTH independent channels (buttons or switches) and feeds the CPU MMIO space and the top-level reset/bp logic.
- Runs entirely on cpu_clk. One shared sample-tick counter serves all channels.

Parameters:
- WIDTH, 4, number of input channels.
- SYNC_STAGES, 2, synchroniser flop depth (>=2).
- SAMPLE_CNT_MAX, 71428, cpu_clk cycles per sample tick (0.5 ms at ~142.86 MHz).
- PULSE_CNT_MAX, 200, consecutive high ticks required for a debounced-high level (100 ms).
- LONG_CNT_MAX, 2000, ticks held after press before the long pulse fires (1 s).
- REPEAT_CNT_MAX, 200, ticks between auto-repeat pulses once long-held.

Ports:
- clk  in  1  cpu_clk.
- rst_n  in  1  reset, synchronous, active-low.
- in  in  WIDTH  raw asynchronous inputs.
- repeat_en  in  WIDTH  per-channel auto-repeat enable; synchronous, sampled every cycle.
- level  out  WIDTH  debounced level, registered.
- press  out  WIDTH  1-cycle pulse on debounced rising edge.
- release_p  out  WIDTH  1-cycle pulse on debounced falling edge.
- long_p  out  WIDTH  1-cycle pulse when hold reaches LONG_CNT_MAX ticks.
- repeat_p  out  WIDTH  1-cycle pulse every REPEAT_CNT_MAX ticks while long-held and repeat_en=1.

Behaviour:
- Reset (rst_n=0 at a clk edge) clears everything: synchroniser flops, tick counter, all channel counters, FSMs to IDLE, and all outputs to 0. Reset asserted mid-hold drops state silently; no release_p is generated.
- Synchroniser:
  - SYNC_STAGES flops per channel, reset to 0.
  - s[i] is the last stage.
- Tick counter:
  - Width $clog2(SAMPLE_CNT_MAX), counts 0..SAMPLE_CNT_MAX-1 and wraps.
  - tick=1 for the one cycle the counter equals SAMPLE_CNT_MAX-1.
- Debounce counter per channel:
  - Width $clog2(PULSE_CNT_MAX+1).
  - s[i]=0 clears it to 0 that cycle, regardless of tick.
  - s[i]=1 with tick increments it, saturating at PULSE_CNT_MAX.
  - Debounced level is deb = (cnt==PULSE_CNT_MAX); level[i] is deb registered.
- Edges:
  - press[i] = deb & ~level[i], registered, so press is high in the same cycle level rises.
  - release_p is the mirror of press.
- Per-channel FSM (hold counter width $clog2(max(LONG_CNT_MAX,REPEAT_CNT_MAX))):
  - IDLE: on deb rising, go to PRESSED and clear the hold counter.
  - PRESSED: on each tick, hold++. Tick with hold==LONG_CNT_MAX-1 gives long_p=1 next cycle, go to HELD, hold=0.
  - HELD:
    - If repeat_en[i], hold++ on each tick. Tick with hold==REPEAT_CNT_MAX-1 gives repeat_p=1 and hold=0.
    - If repeat_en[i]=0, hold is held at 0.
  - Any state: deb falling returns to IDLE, hold=0.
  - Simultaneous release and long/repeat terminal tick: release wins; no long_p or repeat_p is emitted.
- Fixed relationships:
  - long_p and repeat_p never assert while level=0.
  - press and release_p on the same channel never assert in the same cycle.
- Channels are fully independent. Simultaneous events on different channels all pulse in the same cycle.

Decomposition:
- ic_pkg holds the FSM state encodings (IDLE=2'd0, PRESSED=2'd1, HELD=2'd2) and a clog2-width helper function.
- Sub-module ic_channel holds the synchroniser, debounce counter, edge regs and FSM for one channel.
  - It takes tick and repeat_en as inputs.
  - The top generates WIDTH instances and owns the shared tick counter.

Test Plan:
- Bench parameters: SAMPLE_CNT_MAX=4, PULSE_CNT_MAX=3, LONG_CNT_MAX=5, REPEAT_CNT_MAX=2, WIDTH=4, SYNC_STAGES=2.
- Reset: hold rst_n=0 for 3 cycles with in=4'hF -> all outputs 0. After release, press[3:0] rises together and exactly once, 11 ±3 cycles later.
- Bounce: toggle in[0] every 3 cycles for 40 cycles, then hold high -> no press until 3 clean ticks; then exactly one press, and level[0]=1.
- Long + repeat: hold in[1]=1 with repeat_en[1]=1 -> long_p once, 5 ticks (20 cycles) after press; then repeat_p every 8 cycles. Drop in[1] -> exactly one release_p 2-3 cycles after the synchroniser sees 0, and repeat_p stops.
- repeat_en=0: hold in[2] for 200 cycles -> one press, one long_p, zero repeat_p. Setting repeat_en[2]=1 mid-hold gives the first repeat_p within 8 cycles.
- Release/long collision: drop in[3] so deb falls on the long terminal tick -> release_p=1, long_p never asserts.
- Reset mid-hold: assert rst_n=0 while level[1]=1 -> next cycle all outputs 0, no release_p. After rst_n=1 with in still high, a fresh press occurs.

Source files
------------

// File: rtl/ic_pkg.sv
// Shared types and helpers for the input conditioner.
package ic_pkg;

   // Per-channel hold-tracking state.
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PRESSED = 2'd1,
      ST_HELD    = 2'd2
   } ch_state_t;

   // Bit width needed to hold values 0..value-1, never less than one bit.
   function automatic int clog2_w(input int value);
      return (value < 2) ? 1 : $clog2(value);
   endfunction

   function automatic int max_i(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/ic_channel.sv
// One conditioned channel: synchroniser, debounce, edge pulses and the
// press/long/repeat tracker. The sample tick comes from the parent.
module ic_channel
   import ic_pkg::*;
#(
   parameter int SYNC_STAGES    = 2,
   parameter int PULSE_CNT_MAX  = 200,
   parameter int LONG_CNT_MAX   = 2000,
   parameter int REPEAT_CNT_MAX = 200
) (
   input  logic clk,
   input  logic rst_n,
   input  logic in,
   input  logic tick,
   input  logic repeat_en,
   output logic level,
   output logic press,
   output logic release_p,
   output logic long_p,
   output logic repeat_p
);

   localparam int DEB_W  = clog2_w(PULSE_CNT_MAX + 1);
   localparam int HOLD_W = clog2_w(max_i(LONG_CNT_MAX, REPEAT_CNT_MAX));

   localparam logic [DEB_W-1:0]  DEB_MAX   = DEB_W'(PULSE_CNT_MAX);
   localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_CNT_MAX - 1);
   localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'(REPEAT_CNT_MAX - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s;
   logic [DEB_W-1:0]       deb_cnt_q;
   logic                   deb;
   logic                   rise;
   logic                   fall;

   ch_state_t              state_q, state_d;
   logic [HOLD_W-1:0]      hold_q, hold_d;
   logic                   long_d;
   logic                   repeat_d;

   // Bring the asynchronous input into the clk domain.
   always_ff @(posedge clk) begin
      // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], in};
      end
   end

   assign s = sync_q[SYNC_STAGES-1];

   // Count consecutive high samples; any low cycle restarts the count.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         deb_cnt_q <= '0;
      end else if (!s) begin
         deb_cnt_q <= '0;
      end else if (tick && (deb_cnt_q != DEB_MAX)) begin
         deb_cnt_q <= deb_cnt_q + DEB_W'(1);
      end
   end

   assign deb  = (deb_cnt_q == DEB_MAX);
   assign rise = deb & ~level;
   assign fall = ~deb & level;

   // Registered level and edge pulses, all aligned to the same cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         level     <= 1'b0;
         press     <= 1'b0;
         release_p <= 1'b0;
      end else begin
         level     <= deb;
         press     <= rise;
         release_p <= fall;
      end
   end

   // Hold tracker state, hold counter and registered long/repeat pulses.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         hold_q   <= '0;
         long_p   <= 1'b0;
         repeat_p <= 1'b0;
      end else begin
         state_q  <= state_d;
         hold_q   <= hold_d;
         long_p   <= long_d;
         repeat_p <= repeat_d;
      end
   end

   // Next-state logic; a release takes priority over any terminal tick.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      state_d  = state_q;
      hold_d   = hold_q;
      long_d   = 1'b0;
      repeat_d = 1'b0;
      if (fall) begin
         state_d = ST_IDLE;
         hold_d  = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (rise) begin
                  state_d = ST_PRESSED;
                  hold_d  = '0;
               end
            end
            ST_PRESSED: begin
               if (tick) begin
                  if (hold_q == LONG_LAST) begin
                     long_d  = 1'b1;
                     state_d = ST_HELD;
                     hold_d  = '0;
                  end else begin
                     hold_d = hold_q + HOLD_W'(1);
                  end
               end
            end
            ST_HELD: begin
               if (!repeat_en) begin
                  hold_d = '0;
               end else if (tick) begin
                  if (hold_q == REP_LAST) begin
                     repeat_d = 1'b1;
                     hold_d   = '0;
                  end else begin
                     hold_d = hold_q + HOLD_W'(1);
                  end
               end
            end
            default: begin
               state_d = ST_IDLE;
               hold_d  = '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/input_conditioner.sv
// Multi-channel button/switch conditioner with a shared sample tick.
module input_conditioner
   import ic_pkg::*;
#(
   parameter int WIDTH          = 4,
   parameter int SYNC_STAGES    = 2,
   parameter int SAMPLE_CNT_MAX = 71428,
   parameter int PULSE_CNT_MAX  = 200,
   parameter int LONG_CNT_MAX   = 2000,
   parameter int REPEAT_CNT_MAX = 200
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in,
   input  logic [WIDTH-1:0] repeat_en,
   output logic [WIDTH-1:0] level,
   output logic [WIDTH-1:0] press,
   output logic [WIDTH-1:0] release_p,
   output logic [WIDTH-1:0] long_p,
   output logic [WIDTH-1:0] repeat_p
);

   localparam int                TICK_W    = clog2_w(SAMPLE_CNT_MAX);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLE_CNT_MAX - 1);

   logic [TICK_W-1:0] tick_cnt_q;
   logic              tick;

   assign tick = (tick_cnt_q == TICK_LAST);

   // Free-running sample divider shared by every channel.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tick_cnt_q <= '0;
      end else if (tick) begin
         tick_cnt_q <= '0;
      end else begin
         tick_cnt_q <= tick_cnt_q + TICK_W'(1);
      end
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_ch
      ic_channel #(
         .SYNC_STAGES   (SYNC_STAGES),
         .PULSE_CNT_MAX (PULSE_CNT_MAX),
         .LONG_CNT_MAX  (LONG_CNT_MAX),
         .REPEAT_CNT_MAX(REPEAT_CNT_MAX)
      ) u_ch (
         .clk      (clk),
         .rst_n    (rst_n),
         .in       (in[i]),
         .tick     (tick),
         .repeat_en(repeat_en[i]),
         .level    (level[i]),
         .press    (press[i]),
         .release_p(release_p[i]),
         .long_p   (long_p[i]),
         .repeat_p (repeat_p[i])
      );
   end

endmodule
